// File: rtl/ps2_game_keys_if.sv
// ============================================================================
//  Module      : ps2_game_keys_if
//  Description : Bus between the PS/2 byte receiver side and the game-key
//                decoder: scan-code byte strobe in, game controls out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_game_keys_if;
    logic [7:0] key_data;
    logic       key_valid;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic       pause;
    logic [7:0] last_code;

    // Byte source / control consumer side
    modport master (
        output key_data,
        output key_valid,
        input  move_left,
        input  move_right,
        input  fire,
        input  pause,
        input  last_code
    );

    // Decoder side
    modport slave (
        input  key_data,
        input  key_valid,
        output move_left,
        output move_right,
        output fire,
        output pause,
        output last_code
    );
endinterface

`default_nettype wire

// File: rtl/ps2_game_keys.sv
// ============================================================================
//  Module      : ps2_game_keys
//  Description : PS/2 set-2 scan-code decoder producing registered game
//                controls (held left/right, rate-limited fire pulse, pause
//                toggle) and the last decoded key code.
//                Optional feature macro: PS2_AUTOFIRE_EN (fire re-pulses every
//                FIRE_COOLDOWN cycles while space is held and not paused).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_game_keys #(
    parameter int FIRE_COOLDOWN = 2500000,
    parameter int SKIP_E1       = 7
) (
    input  logic            clock,
    input  logic            reset,
    ps2_game_keys_if.slave  bus
);

    localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);
    localparam int SK_W = (SKIP_E1 < 1) ? 1 : $clog2(SKIP_E1 + 1);
    localparam logic [CD_W-1:0] c_cd_load = CD_W'(FIRE_COOLDOWN - 1);
    localparam logic [SK_W-1:0] c_sk_load = SK_W'(SKIP_E1);

    localparam logic [7:0] c_ext    = 8'hE0;
    localparam logic [7:0] c_brk    = 8'hF0;
    localparam logic [7:0] c_e1     = 8'hE1;
    localparam logic [7:0] c_larrow = 8'h6B;   // extended
    localparam logic [7:0] c_rarrow = 8'h74;   // extended
    localparam logic [7:0] c_key_a  = 8'h1C;
    localparam logic [7:0] c_key_d  = 8'h23;
    localparam logic [7:0] c_space  = 8'h29;
    localparam logic [7:0] c_key_p  = 8'h4D;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    state_t          state;
    logic [SK_W-1:0] skip_cnt;
    logic [CD_W-1:0] cooldown;

    logic l_arrow, l_a, r_arrow, r_d, fire_held, p_held;
    logic pause_q, fire_q, move_left_q, move_right_q;
    logic [7:0] last_code_q;

    // Decode strobe for the current byte
    logic dec_valid, dec_ext, dec_brk;
    logic hit_l_arrow, hit_l_a, hit_r_arrow, hit_r_d, hit_fire, hit_p;
    logic l_arrow_n, l_a_n, r_arrow_n, r_d_n, fire_held_n, p_held_n;
    logic pause_n, left_n, right_n;
    logic fire_make, fire_auto, fire_issue;

    // Classify the incoming byte: is it the final byte of a make/break?
    always_comb begin
        dec_valid = 1'b0;
        dec_ext   = 1'b0;
        dec_brk   = 1'b0;
        if (bus.key_valid) begin
            case (state)
                ST_IDLE: dec_valid = (bus.key_data != c_ext) &&
                                     (bus.key_data != c_brk) &&
                                     (bus.key_data != c_e1);
                ST_EXT: begin
                    dec_valid = (bus.key_data != c_brk);
                    dec_ext   = 1'b1;
                end
                ST_BRK: begin
                    dec_valid = 1'b1;
                    dec_brk   = 1'b1;
                end
                ST_EXT_BRK: begin
                    dec_valid = 1'b1;
                    dec_ext   = 1'b1;
                    dec_brk   = 1'b1;
                end
                default: dec_valid = 1'b0;
            endcase
        end
    end

    // Key map, flag next-state, pause toggle and fire issue
    always_comb begin
        hit_l_arrow = dec_valid &&  dec_ext && (bus.key_data == c_larrow);
        hit_r_arrow = dec_valid &&  dec_ext && (bus.key_data == c_rarrow);
        hit_l_a     = dec_valid && !dec_ext && (bus.key_data == c_key_a);
        hit_r_d     = dec_valid && !dec_ext && (bus.key_data == c_key_d);
        hit_fire    = dec_valid && !dec_ext && (bus.key_data == c_space);
        hit_p       = dec_valid && !dec_ext && (bus.key_data == c_key_p);

        l_arrow_n   = hit_l_arrow ? !dec_brk : l_arrow;
        l_a_n       = hit_l_a     ? !dec_brk : l_a;
        r_arrow_n   = hit_r_arrow ? !dec_brk : r_arrow;
        r_d_n       = hit_r_d     ? !dec_brk : r_d;
        fire_held_n = hit_fire    ? !dec_brk : fire_held;
        p_held_n    = hit_p       ? !dec_brk : p_held;

        // Typematic repeats of P arrive with p_held set and are ignored
        pause_n = pause_q ^ (hit_p && !dec_brk && !p_held);
        left_n  = l_arrow_n | l_a_n;
        right_n = r_arrow_n | r_d_n;

        fire_make = hit_fire && !dec_brk && !fire_held && !pause_q &&
                    (cooldown == '0);
`ifdef PS2_AUTOFIRE_EN
        fire_auto = fire_held && !pause_q && (cooldown == '0);
`else
        fire_auto = 1'b0;
`endif
        fire_issue = fire_make | fire_auto;
    end

    // Prefix tracker: E0/F0/E1 prefixes and the E1 discard counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else if (bus.key_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.key_data == c_ext) begin
                        state <= ST_EXT;
                    end else if (bus.key_data == c_brk) begin
                        state <= ST_BRK;
                    end else if (bus.key_data == c_e1) begin
                        if (SKIP_E1 > 0) begin
                            state    <= ST_SKIP;
                            skip_cnt <= c_sk_load;
                        end
                    end
                end
                ST_EXT:     state <= (bus.key_data == c_brk) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK:     state <= ST_IDLE;
                ST_EXT_BRK: state <= ST_IDLE;
                ST_SKIP: begin
                    if (skip_cnt <= SK_W'(1)) begin
                        state    <= ST_IDLE;
                        skip_cnt <= '0;
                    end else begin
                        skip_cnt <= skip_cnt - SK_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Held flags, pause, fire cooldown and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            l_arrow      <= 1'b0;
            l_a          <= 1'b0;
            r_arrow      <= 1'b0;
            r_d          <= 1'b0;
            fire_held    <= 1'b0;
            p_held       <= 1'b0;
            pause_q      <= 1'b0;
            fire_q       <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            last_code_q  <= 8'h00;
            cooldown     <= '0;
        end else begin
            l_arrow      <= l_arrow_n;
            l_a          <= l_a_n;
            r_arrow      <= r_arrow_n;
            r_d          <= r_d_n;
            fire_held    <= fire_held_n;
            p_held       <= p_held_n;
            pause_q      <= pause_n;
            fire_q       <= fire_issue;
            move_left_q  <= left_n  & ~right_n & ~pause_n;
            move_right_q <= right_n & ~left_n  & ~pause_n;
            if (dec_valid) begin
                last_code_q <= bus.key_data;
            end
            // Cooldown keeps running through pause; saturates at zero
            if (fire_issue) begin
                cooldown <= c_cd_load;
            end else if (cooldown != '0) begin
                cooldown <= cooldown - CD_W'(1);
            end
        end
    end

    assign bus.move_left  = move_left_q;
    assign bus.move_right = move_right_q;
    assign bus.fire       = fire_q;
    assign bus.pause      = pause_q;
    assign bus.last_code  = last_code_q;

endmodule

`default_nettype wire
